studioii_keypad: RTL and testbench
==================================

Name: studioii_keypad

Overview:
- Receiving end of the `ps2_key` event stream produced by hps_io.
- Decodes make/break events into the two Studio II 10-key keypads and holds the pressed/released state of each key.
- Answers the CPU keypad query: the CPU latches a key number with OUT 2, then samples EF3 (player 1) and EF4 (player 2).
- Sits inside `rcastudioii`, between hps_io `ps2_key` and the CDP1802 EF/OUT decode.

Parameters:
- P2_NUMPAD, 1, 1 = player 2 on the numeric keypad; 0 = player 2 disabled (`pad2` held at 0).

Ports:
- `clk` in 1: system clock (`clk_sys`).
- `reset_n` in 1: synchronous reset, active-low.
- `ps2_key` in 11: [10] toggle per event, [9] 1 = make / 0 = break, [8] extended flag, [7:0] set-2 scancode.
- `clear` in 1: synchronous clear of all key state, level-sensitive; driven from `ioctl_download`.
- `sel_wr` in 1: one-cycle strobe, CPU OUT 2.
- `sel_data` in 4: key number 0-9; 10-15 selects no key.
- `ef3` out 1: 1 = selected key is held on pad 1.
- `ef4` out 1: 1 = selected key is held on pad 2.
- `pad1` out 10: held-key bitmap for player 1, bit n = key n.
- `pad2` out 10: held-key bitmap for player 2.
- `sel` out 4: current select latch.

Behaviour:
- Event detect:
  - New event in cycle N when `ps2_key[10]` != `prev_tgl`; `prev_tgl` <= `ps2_key[10]` every cycle.
  - Events are processed only in the cycle the toggle changes; `ps2_key` [9:0] are sampled in that cycle.
- Decode:
  - Only events with `ps2_key[8]` = 0 are decoded; any event with [8] = 1 is ignored.
  - Pad 1 (main-row digits), key0-key9 scancodes: 45, 16, 1E, 26, 25, 2E, 36, 3D, 3E, 46.
  - Pad 2 (numpad), key0-key9 scancodes: 70, 69, 72, 7A, 6B, 73, 74, 6C, 75, 7D.
  - Unmapped scancodes are ignored.
- Key state:
  - Matching bit <= `ps2_key[9]`. Make on a held key, and break on a released key, are idempotent.
  - Bitmap update is visible at N+1.
- Select latch:
  - `sel` <= `sel_data` on `sel_wr`, visible at the next cycle.
  - Values 10-15 are stored unchanged; they match no key.
- EF outputs, registered every cycle:
  - `ef3` <= (`sel` < 10) & `pad1[sel]`.
  - `ef4` <= (`sel` < 10) & `pad2[sel]`.
  - Latency: key event in cycle N → `ef` at N+2. `sel_wr` in cycle N → `ef` at N+2.
- Simultaneous events:
  - A key event and `sel_wr` in the same cycle both take effect.
  - `ef` at N+2 reflects both the new `sel` and the new bitmap.
- `clear`:
  - While high: `pad1` = `pad2` = 0, and decoded events are discarded.
  - `prev_tgl` keeps tracking, so no stale event fires when `clear` falls.
  - `sel` is unaffected.
  - Clear wins over a same-cycle make.
- Reset (`reset_n` = 0 at a clock edge), applied from any state including mid-event:
  - `pad1` = `pad2` = 0, `sel` = 4'hF, `ef3` = `ef4` = 0.
  - `prev_tgl` <= `ps2_key[10]`, so no spurious event on the first cycle after release.
- Multiple held keys are fully independent; there is no rollover limit.
- P2_NUMPAD = 0: numpad scancodes are ignored and `pad2`/`ef4` stay 0.

Test Plan:
- Reset release with `ps2_key` = 11'h400 (toggle 1, idle) → no event; `pad1` = `pad2` = 0, `sel` = F, `ef3` = `ef4` = 0 for 10 cycles.
- Toggle flip with make 1E (`ps2_key` = 11'h21E after 11'h400) → `pad1` = 10'h004 at N+1. `sel_wr` `sel_data` = 2 → `ef3` = 1, `ef4` = 0 two cycles later. Break 1E → `pad1` = 0, `ef3` = 0 at N+2.
- Make numpad 7D with `sel` = 9 → `pad2` = 10'h200, `ef4` = 1. Same scancode with [8] = 1 → no change. Make scancode 1C → no change.
- Hold keys 1, 5 on pad 1, then `sel_wr` with `sel_data` = 5 in the same cycle as break of key 5 → `ef3` = 0 at N+2, `pad1` = 10'h002. `sel` = 12 → `ef3` = 0 with key 1 still held.
- `clear` high 3 cycles while key 3 held and a make-8 event arrives → `pad1` = 0 throughout. After `clear` falls with no new toggle → `pad1` stays 0 and `sel` keeps its prior value.
- `reset_n` low for one cycle during a make event with keys held → all outputs at reset values. No event is detected afterwards until the next toggle flip.

Source files
------------

// File: rtl/studioii_keypad.sv
// Studio II keypad receiver.
// Turns ps2_key make/break events into two 10-key bitmaps (main-row digits on
// pad 1, numeric keypad on pad 2). It also answers the CPU keypad query: a key
// number is latched by OUT 2, and EF3/EF4 then report whether that key is held.
module studioii_keypad #(
  parameter bit P2_NUMPAD = 1'b1      // 1: pad 2 on numpad, 0: pad 2 disabled
) (
  input  logic        clk,
  input  logic        reset_n,        // synchronous, active-low
  input  logic [10:0] ps2_key,        // [10] toggle, [9] make, [8] ext, [7:0] code
  input  logic        clear,          // level-sensitive wipe of all key state
  input  logic        sel_wr,         // OUT 2 strobe
  input  logic [3:0]  sel_data,       // key number, 10-15 selects nothing
  output logic        ef3,
  output logic        ef4,
  output logic [9:0]  pad1,
  output logic [9:0]  pad2,
  output logic [3:0]  sel
);

  // Set-2 scancodes for key0..key9 of each pad.
  localparam logic [7:0] P1_CODES [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
  };
  localparam logic [7:0] P2_CODES [10] = '{
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
  };

  logic       r_prev_tgl;
  logic [9:0] r_pad1;
  logic [9:0] r_pad2;
  logic [3:0] r_sel;
  logic       r_ef3;
  logic       r_ef4;

  logic       w_event;
  logic       w_decode_en;
  logic       w_make;
  logic [9:0] w_p1_match;
  logic [9:0] w_p2_match;
  logic [9:0] w_p1_set;
  logic [9:0] w_p2_set;
  logic [9:0] w_sel_onehot;

  // An event is a change of the toggle bit. Extended codes never decode.
  assign w_event     = ps2_key[10] ^ r_prev_tgl;
  assign w_decode_en = w_event & ~ps2_key[8];
  assign w_make      = ps2_key[9];

  // Per-key scancode comparators and select decode. Codes 10-15 of the
  // select latch produce an all-zero one-hot, so they match no key.
  for (genvar gi = 0; gi < 10; gi++) begin : g_key
    assign w_p1_match[gi]   = (ps2_key[7:0] == P1_CODES[gi]);
    assign w_p2_match[gi]   = (ps2_key[7:0] == P2_CODES[gi]);
    assign w_sel_onehot[gi] = (r_sel == 4'(gi));
  end

  // Bits to be written this cycle. Pad 2 is masked off when not fitted.
  assign w_p1_set = w_p1_match & {10{w_decode_en}};
  assign w_p2_set = w_p2_match & {10{w_decode_en & P2_NUMPAD}};

  // Toggle tracker: follows ps2_key[10] every cycle, including reset and
  // clear, so neither can leave a stale event behind.
  always_ff @(posedge clk) begin
    r_prev_tgl <= ps2_key[10];
  end

  // Key bitmaps: matching bit takes the make/break flag; clear wins.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_pad1 <= '0;
      r_pad2 <= '0;
    end else begin
      r_pad1 <= (r_pad1 & ~w_p1_set) | (w_p1_set & {10{w_make}});
      r_pad2 <= (r_pad2 & ~w_p2_set) | (w_p2_set & {10{w_make}});
    end
  end

  // Select latch written by OUT 2; idles at F (no key).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sel <= 4'hF;
    end else if (sel_wr) begin
      r_sel <= sel_data;
    end
  end

  // EF flags re-evaluated every cycle from the registered select and bitmaps.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ef3 <= 1'b0;
      r_ef4 <= 1'b0;
    end else begin
      r_ef3 <= |(r_pad1 & w_sel_onehot);
      r_ef4 <= |(r_pad2 & w_sel_onehot);
    end
  end

  assign pad1 = r_pad1;
  assign pad2 = r_pad2;
  assign sel  = r_sel;
  assign ef3  = r_ef3;
  assign ef4  = r_ef4;

endmodule

// File: tb/tb_studioii_keypad.sv
// Directed bench for studioii_keypad. A second instance with pad 2 disabled
// shares all inputs.
module tb_studioii_keypad;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        clear;
  logic        sel_wr;
  logic [3:0]  sel_data;
  logic        ef3, ef4;
  logic [9:0]  pad1, pad2;
  logic [3:0]  sel;
  logic        ef3_b, ef4_b;
  logic [9:0]  pad1_b, pad2_b;
  logic [3:0]  sel_b;

  int n_checks = 0;
  int n_errors = 0;
  logic tgl = 1'b1;

  always #5 clk = ~clk;

  studioii_keypad #(.P2_NUMPAD(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .clear(clear),
    .sel_wr(sel_wr), .sel_data(sel_data),
    .ef3(ef3), .ef4(ef4), .pad1(pad1), .pad2(pad2), .sel(sel)
  );

  studioii_keypad #(.P2_NUMPAD(1'b0)) dut_nop2 (
    .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .clear(clear),
    .sel_wr(sel_wr), .sel_data(sel_data),
    .ef3(ef3_b), .ef4(ef4_b), .pad1(pad1_b), .pad2(pad2_b), .sel(sel_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a new ps2 event (flips the toggle bit).
  task automatic send(input logic make, input logic ext, input logic [7:0] code);
    tgl = ~tgl;
    ps2_key = {tgl, make, ext, code};
    $display("event: make=%0d ext=%0d code=%02h", make, ext, code);
  endtask

  task automatic write_sel(input logic [3:0] v);
    sel_wr   = 1'b1;
    sel_data = v;
    $display("sel_wr: %0d", v);
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_key  = 11'h400;
    clear    = 1'b0;
    sel_wr   = 1'b0;
    sel_data = 4'h0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Idle after reset: no event, reset values held.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_pad1", 32'(pad1), 32'h0);
      check("rst_pad2", 32'(pad2), 32'h0);
      check("rst_sel",  32'(sel),  32'hF);
      check("rst_ef3",  32'(ef3),  32'h0);
      check("rst_ef4",  32'(ef4),  32'h0);
    end

    // Make 1E (key 2, pad 1).
    send(1'b1, 1'b0, 8'h1E);
    check("tb_key_word", 32'(ps2_key), 32'h21E);
    tick();
    check("make2_pad1", 32'(pad1), 32'h004);
    write_sel(4'd2);
    tick();
    sel_wr = 1'b0;
    check("sel2", 32'(sel), 32'h2);
    check("sel2_ef3_n1", 32'(ef3), 32'h0);
    tick();
    check("sel2_ef3", 32'(ef3), 32'h1);
    check("sel2_ef4", 32'(ef4), 32'h0);

    // Break 1E.
    send(1'b0, 1'b0, 8'h1E);
    tick();
    check("brk2_pad1", 32'(pad1), 32'h0);
    check("brk2_ef3_n1", 32'(ef3), 32'h1);
    tick();
    check("brk2_ef3_n2", 32'(ef3), 32'h0);

    // Numpad 7D (key 9, pad 2) with sel=9 in the same cycle.
    write_sel(4'd9);
    send(1'b1, 1'b0, 8'h7D);
    tick();
    sel_wr = 1'b0;
    check("np9_pad2", 32'(pad2), 32'h200);
    check("np9_pad1", 32'(pad1), 32'h0);
    check("np9_nop2_pad2", 32'(pad2_b), 32'h0);
    tick();
    check("np9_ef4", 32'(ef4), 32'h1);
    check("np9_ef3", 32'(ef3), 32'h0);
    check("np9_nop2_ef4", 32'(ef4_b), 32'h0);

    // Extended break of 7D is ignored.
    send(1'b0, 1'b1, 8'h7D);
    tick();
    check("ext_pad2", 32'(pad2), 32'h200);
    tick();
    check("ext_ef4", 32'(ef4), 32'h1);

    // Unmapped scancode 1C is ignored.
    send(1'b1, 1'b0, 8'h1C);
    tick();
    check("unmap_pad1", 32'(pad1), 32'h0);
    check("unmap_pad2", 32'(pad2), 32'h200);

    send(1'b0, 1'b0, 8'h7D);
    tick();
    check("np9_brk_pad2", 32'(pad2), 32'h0);

    // Hold keys 1 and 5, then break 5 together with sel=5.
    send(1'b1, 1'b0, 8'h16);
    tick();
    send(1'b1, 1'b0, 8'h2E);
    tick();
    check("hold15_pad1", 32'(pad1), 32'h022);
    write_sel(4'd5);
    send(1'b0, 1'b0, 8'h2E);
    tick();
    sel_wr = 1'b0;
    check("brk5_pad1", 32'(pad1), 32'h002);
    check("brk5_sel", 32'(sel), 32'h5);
    tick();
    check("brk5_ef3", 32'(ef3), 32'h0);

    write_sel(4'd1);
    tick();
    sel_wr = 1'b0;
    tick();
    check("sel1_ef3", 32'(ef3), 32'h1);

    write_sel(4'd12);
    tick();
    sel_wr = 1'b0;
    tick();
    check("sel12_sel", 32'(sel), 32'hC);
    check("sel12_ef3", 32'(ef3), 32'h0);
    check("sel12_pad1", 32'(pad1), 32'h002);

    // Clear while key 3 held and a make-8 arrives.
    send(1'b1, 1'b0, 8'h26);
    tick();
    check("hold13_pad1", 32'(pad1), 32'h00A);
    clear = 1'b1;
    $display("clear: 1");
    send(1'b1, 1'b0, 8'h3E);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clr_pad1", 32'(pad1), 32'h0);
    end
    clear = 1'b0;
    $display("clear: 0");
    for (int i = 0; i < 2; i++) begin
      tick();
      check("postclr_pad1", 32'(pad1), 32'h0);
    end
    check("postclr_sel", 32'(sel), 32'hC);

    // Reset during a make event with a key held.
    send(1'b1, 1'b0, 8'h16);
    tick();
    check("prerst_pad1", 32'(pad1), 32'h002);
    reset_n = 1'b0;
    send(1'b1, 1'b0, 8'h46);
    tick();
    reset_n = 1'b1;
    check("mrst_pad1", 32'(pad1), 32'h0);
    check("mrst_pad2", 32'(pad2), 32'h0);
    check("mrst_sel",  32'(sel),  32'hF);
    check("mrst_ef3",  32'(ef3),  32'h0);
    check("mrst_ef4",  32'(ef4),  32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_pad1", 32'(pad1), 32'h0);
    end
    send(1'b1, 1'b0, 8'h46);
    tick();
    check("postrst_make9", 32'(pad1), 32'h200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
